// File: rtl/bmem_burst_responder.sv
// bmem_burst_responder
// Memory-side responder for the 64-bit burst memory interface. One line
// request is accepted at a time. Each 256-bit line moves as 4 consecutive
// 64-bit beats, low word first, for both reads and writes. Storage is an
// internal array of 2**ADDR_BITS lines. The array contents are not reset.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bmem_address  byte address of the line; bits [4:0] ignored, upper bits alias
//   bmem_read     read request, held by the initiator until the final beat
//   bmem_write    write request, held by the initiator until the final beat
//   bmem_wdata    write beat data, beat k presented until its resp
//   bmem_rdata    read beat data, valid with bmem_resp during a read
//   bmem_resp     beat strobe, 4 consecutive high cycles per request
//   busy          high in every state except IDLE
//
// Optional build macro: BMEM_VARIABLE_LATENCY_EN
//   When defined, an 8-bit LFSR adds 0..3 extra wait cycles per request.
module bmem_burst_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bmem_address,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [63:0] bmem_wdata,
    output logic [63:0] bmem_rdata,
    output logic        bmem_resp,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RBURST,
        S_WBURST,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_BITS-1:0] r_idx;
    logic                 r_is_rd;
    logic [1:0]           r_beat;
    logic [4:0]           r_lat;
    logic [255:0]         r_mem [0:(1<<ADDR_BITS)-1];

    logic                 w_accept;
    logic [ADDR_BITS-1:0] w_idx_req;
    logic [ADDR_BITS-1:0] w_rd_idx;
    logic [1:0]           w_rd_sel;
    logic [63:0]          w_rd_word;
    logic [7:0]           w_rd_off;
    logic [7:0]           w_wr_off;
    logic [4:0]           w_lat_req;
    logic                 w_unused_addr;

    // Address bits outside the line index are intentionally ignored.
    assign w_unused_addr = ^bmem_address;

    assign w_accept  = (r_state == S_IDLE) && (bmem_read || bmem_write);
    assign w_idx_req = bmem_address[5 +: ADDR_BITS];

`ifdef BMEM_VARIABLE_LATENCY_EN
    // Fibonacci LFSR, taps 8,6,5,4. Extra latency uses the value before it advances.
    logic [7:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 8'hA5;
        end else if (w_accept) begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_lat_req = 5'(LATENCY) + {3'd0, r_lfsr[1:0]};
`else
    assign w_lat_req = 5'(LATENCY);
`endif

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_lat_req != 5'd0) begin
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_state_nxt = bmem_read ? S_RBURST : S_WBURST;
                    end
                end
            end
            S_WAIT: begin
                if (r_lat <= 5'd1) begin
                    w_state_nxt = r_is_rd ? S_RBURST : S_WBURST;
                end
            end
            S_RBURST, S_WBURST: begin
                if (r_beat == 2'd3) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read data is fetched one cycle ahead so it lands together with resp.
    // Entering the burst from IDLE (zero latency) the line index is still on the bus.
    assign w_rd_idx  = (r_state == S_IDLE) ? w_idx_req : r_idx;
    assign w_rd_sel  = (r_state == S_RBURST) ? (r_beat + 2'd1) : 2'd0;
    assign w_rd_off  = {w_rd_sel, 6'd0};
    assign w_rd_word = r_mem[w_rd_idx][w_rd_off +: 64];
    assign w_wr_off  = {r_beat, 6'd0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_beat     <= 2'd0;
            r_lat      <= 5'd0;
            r_idx      <= '0;
            r_is_rd    <= 1'b0;
            bmem_rdata <= 64'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_idx   <= w_idx_req;
                r_is_rd <= bmem_read;
                r_lat   <= w_lat_req;
            end else if (r_state == S_WAIT) begin
                r_lat <= r_lat - 5'd1;
            end
            if (r_state == S_RBURST || r_state == S_WBURST) begin
                r_beat <= r_beat + 2'd1;
            end else begin
                r_beat <= 2'd0;
            end
            if (w_state_nxt == S_RBURST) begin
                bmem_rdata <= w_rd_word;
            end
        end
    end

    // Each write beat commits on its own; a reset cycle commits nothing.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_WBURST) begin
            r_mem[r_idx][w_wr_off +: 64] <= bmem_wdata;
        end
    end

    assign bmem_resp = (r_state == S_RBURST) || (r_state == S_WBURST);
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_bmem_burst_responder.sv
// Testbench for bmem_burst_responder. Instance A uses LATENCY=4, instance B
// uses LATENCY=0; with BMEM_VARIABLE_LATENCY_EN a third instance C uses
// LATENCY=2. Inputs are driven and outputs sampled on the falling clock edge.
module tb_bmem_burst_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] a_addr = '0;
    logic        a_rd = 1'b0, a_wr = 1'b0;
    logic [63:0] a_wdata = '0, a_rdata;
    logic        a_resp, a_busy;

    logic [31:0] b_addr = '0;
    logic        b_rd = 1'b0, b_wr = 1'b0;
    logic [63:0] b_wdata = '0, b_rdata;
    logic        b_resp, b_busy;

    bmem_burst_responder #(.ADDR_BITS(8), .LATENCY(4)) u_dut_a (
        .clk(clk), .rst(rst), .bmem_address(a_addr), .bmem_read(a_rd),
        .bmem_write(a_wr), .bmem_wdata(a_wdata), .bmem_rdata(a_rdata),
        .bmem_resp(a_resp), .busy(a_busy)
    );

    bmem_burst_responder #(.ADDR_BITS(8), .LATENCY(0)) u_dut_b (
        .clk(clk), .rst(rst), .bmem_address(b_addr), .bmem_read(b_rd),
        .bmem_write(b_wr), .bmem_wdata(b_wdata), .bmem_rdata(b_rdata),
        .bmem_resp(b_resp), .busy(b_busy)
    );

`ifdef BMEM_VARIABLE_LATENCY_EN
    logic [31:0] c_addr = '0;
    logic        c_rd = 1'b0, c_wr = 1'b0;
    logic [63:0] c_wdata = '0, c_rdata;
    logic        c_resp, c_busy;

    bmem_burst_responder #(.ADDR_BITS(8), .LATENCY(2)) u_dut_c (
        .clk(clk), .rst(rst), .bmem_address(c_addr), .bmem_read(c_rd),
        .bmem_write(c_wr), .bmem_wdata(c_wdata), .bmem_rdata(c_rdata),
        .bmem_resp(c_resp), .busy(c_busy)
    );

    logic [7:0] lf_a = 8'hA5, lf_b = 8'hA5;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction
`endif

    // Extra wait cycles the next accepted request on A / B will see.
    task automatic extra_a(output int x);
`ifdef BMEM_VARIABLE_LATENCY_EN
        x = int'(lf_a[1:0]);
        lf_a = lfsr_step(lf_a);
`else
        x = 0;
`endif
    endtask

    task automatic extra_b(output int x);
`ifdef BMEM_VARIABLE_LATENCY_EN
        x = int'(lf_b[1:0]);
        lf_b = lfsr_step(lf_b);
`else
        x = 0;
`endif
    endtask

    function automatic logic [255:0] mk(input logic [63:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    // One request on A. lat counts falling edges from request until the first
    // resp (1 + latency). Returns at the falling edge of the DONE cycle, or one
    // cycle later with the request still high when hold is set.
    task automatic req_a(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] wl, input bit hold,
                         output logic [255:0] rl, output int lat, output int nb);
        @(negedge clk);
        a_addr = addr; a_rd = rd; a_wr = wr; a_wdata = wl[63:0];
        lat = 0; nb = 0; rl = '0;
        while (a_resp !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        while (a_resp === 1'b1 && nb < 8) begin
            if (nb < 4) begin
                a_wdata = wl[64*nb +: 64];
                rl[64*nb +: 64] = a_rdata;
            end
            nb++;
            @(negedge clk);
        end
        if (hold) @(negedge clk);
        a_rd = 1'b0; a_wr = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (a_resp !== 1'b0) begin errors++; $display("FAIL reset_resp_a: got %b expected 0", a_resp); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy_a: got %b expected 0", a_busy); end
        checks++; if (a_rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata_a: got %h expected 0", a_rdata); end
        checks++; if (b_resp !== 1'b0) begin errors++; $display("FAIL reset_resp_b: got %b expected 0", b_resp); end
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_busy_b: got %b expected 0", b_busy); end
        checks++; if (b_rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata_b: got %h expected 0", b_rdata); end
        rst = 1'b0;
    endtask

    task automatic test_write_read;
        logic [255:0] l1, rl;
        int lat, nb, ex;
        l1 = mk(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        extra_a(ex);
        req_a(1'b0, 1'b1, 32'h0000_0040, l1, 1'b0, rl, lat, nb);
        checks++; if (lat !== 5 + ex) begin errors++; $display("FAIL wr_latency: got %0d expected %0d", lat, 5 + ex); end
        checks++; if (nb !== 4) begin errors++; $display("FAIL wr_beats: got %0d expected 4", nb); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL done_busy: got %b expected 1", a_busy); end
        extra_a(ex);
        req_a(1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, rl, lat, nb);
        checks++; if (lat !== 5 + ex) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", lat, 5 + ex); end
        checks++; if (nb !== 4) begin errors++; $display("FAIL rd_beats: got %0d expected 4", nb); end
        checks++; if (rl !== l1) begin errors++; $display("FAIL rd_data: got %h expected %h", rl, l1); end
    endtask

    task automatic test_alias;
        logic [255:0] ld, rl;
        int lat, nb, ex;
        ld = mk(64'hDEAD_BEEF_0000_0000, 64'hDEAD_BEEF_0000_0001,
                64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0003);
        extra_a(ex);
        req_a(1'b0, 1'b1, 32'h0000_2000, ld, 1'b0, rl, lat, nb);
        extra_a(ex);
        req_a(1'b1, 1'b0, 32'h0000_0000, '0, 1'b0, rl, lat, nb);
        checks++; if (rl !== ld) begin errors++; $display("FAIL alias_upper: got %h expected %h", rl, ld); end
        extra_a(ex);
        req_a(1'b1, 1'b0, 32'h0000_001F, '0, 1'b0, rl, lat, nb);
        checks++; if (rl !== ld) begin errors++; $display("FAIL alias_low5: got %h expected %h", rl, ld); end
        checks++; if (lat !== 5 + ex) begin errors++; $display("FAIL alias_latency: got %0d expected %0d", lat, 5 + ex); end
    endtask

    task automatic test_simultaneous;
        logic [255:0] l80, lx, rl;
        int lat, nb, ex;
        l80 = mk(64'h8080_0000_0000_0000, 64'h8080_0000_0000_0001,
                 64'h8080_0000_0000_0002, 64'h8080_0000_0000_0003);
        lx  = mk(64'hBAD0_BAD0_BAD0_BAD0, 64'hBAD1_BAD1_BAD1_BAD1,
                 64'hBAD2_BAD2_BAD2_BAD2, 64'hBAD3_BAD3_BAD3_BAD3);
        extra_a(ex);
        req_a(1'b0, 1'b1, 32'h0000_0080, l80, 1'b0, rl, lat, nb);
        extra_a(ex);
        req_a(1'b1, 1'b1, 32'h0000_0080, lx, 1'b1, rl, lat, nb);
        checks++; if (rl !== l80) begin errors++; $display("FAIL rw_read_wins: got %h expected %h", rl, l80); end
        checks++; if (nb !== 4) begin errors++; $display("FAIL rw_beats: got %0d expected 4", nb); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL after_done_busy: got %b expected 0", a_busy); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (a_resp !== 1'b0 || a_busy !== 1'b0) begin
                errors++; $display("FAIL no_second_burst[%0d]: got resp=%b busy=%b expected 0 0", i, a_resp, a_busy);
            end
        end
        extra_a(ex);
        req_a(1'b1, 1'b0, 32'h0000_0080, '0, 1'b0, rl, lat, nb);
        checks++; if (rl !== l80) begin errors++; $display("FAIL rw_line_unchanged: got %h expected %h", rl, l80); end
    endtask

    task automatic test_reset_mid_burst;
        logic [255:0] lo, ln, rl, exp_l;
        int lat, nb, ex;
        lo = mk(64'h0A0A_0A0A_0000_0000, 64'h0A0A_0A0A_0000_0001,
                64'h0A0A_0A0A_0000_0002, 64'h0A0A_0A0A_0000_0003);
        ln = mk(64'h5555_5555_0000_0000, 64'h5555_5555_0000_0001,
                64'h5555_5555_0000_0002, 64'h5555_5555_0000_0003);
        exp_l = {lo[255:128], ln[127:0]};
        extra_a(ex);
        req_a(1'b0, 1'b1, 32'h0000_0100, lo, 1'b0, rl, lat, nb);
        extra_a(ex);
        @(negedge clk);
        a_addr = 32'h0000_0100; a_wr = 1'b1; a_wdata = ln[63:0];
        lat = 0;
        while (a_resp !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        checks++; if (lat !== 5 + ex) begin errors++; $display("FAIL rstwr_latency: got %0d expected %0d", lat, 5 + ex); end
        @(negedge clk);
        a_wdata = ln[127:64];
        @(negedge clk);
        // Beat 2 cycle: reset before its commit edge.
        checks++; if (a_resp !== 1'b1) begin errors++; $display("FAIL rstwr_beat2_resp: got %b expected 1", a_resp); end
        a_wdata = ln[191:128];
        rst = 1'b1; a_wr = 1'b0;
        @(negedge clk);
        checks++; if (a_resp !== 1'b0) begin errors++; $display("FAIL rst_mid_resp: got %b expected 0", a_resp); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", a_busy); end
        rst = 1'b0;
`ifdef BMEM_VARIABLE_LATENCY_EN
        lf_a = 8'hA5; lf_b = 8'hA5;
`endif
        extra_a(ex);
        req_a(1'b1, 1'b0, 32'h0000_0100, '0, 1'b0, rl, lat, nb);
        checks++; if (rl !== exp_l) begin errors++; $display("FAIL rst_partial_line: got %h expected %h", rl, exp_l); end
    endtask

    task automatic test_zero_latency;
        int t, t1, t2, nb1, nb2, e1, e2;
        extra_b(e1);
        extra_b(e2);
        @(negedge clk);
        b_addr = 32'h0000_0040; b_rd = 1'b1;
        t = 0; nb1 = 0; nb2 = 0;
        while (b_resp !== 1'b1 && t < 60) begin @(negedge clk); t++; end
        t1 = t;
        while (b_resp === 1'b1 && nb1 < 8) begin nb1++; @(negedge clk); t++; end
        // Request stays high: the second burst starts after DONE and IDLE.
        while (b_resp !== 1'b1 && t < 60) begin @(negedge clk); t++; end
        t2 = t;
        while (b_resp === 1'b1 && nb2 < 8) begin nb2++; @(negedge clk); t++; end
        b_rd = 1'b0;
        checks++; if (t1 !== 1 + e1) begin errors++; $display("FAIL lat0_first_resp: got %0d expected %0d", t1, 1 + e1); end
        checks++; if (nb1 !== 4) begin errors++; $display("FAIL lat0_beats1: got %0d expected 4", nb1); end
        checks++; if (t2 !== 7 + e1 + e2) begin errors++; $display("FAIL b2b_second_resp: got %0d expected %0d", t2, 7 + e1 + e2); end
        checks++; if (nb2 !== 4) begin errors++; $display("FAIL lat0_beats2: got %0d expected 4", nb2); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL lat0_idle_busy: got %b expected 0", b_busy); end
    endtask

`ifdef BMEM_VARIABLE_LATENCY_EN
    task automatic test_var_latency;
        int lat, nb;
        for (int r = 0; r < 65; r++) begin
            @(negedge clk);
            c_addr = 32'($urandom);
            c_rd = 1'($urandom_range(0, 1));
            c_wr = ~c_rd;
            c_wdata = {$urandom, $urandom};
            lat = 0; nb = 0;
            while (c_resp !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
            while (c_resp === 1'b1 && nb < 8) begin nb++; @(negedge clk); end
            c_rd = 1'b0; c_wr = 1'b0;
            if (r == 0) begin
                checks++; if (lat !== 4) begin errors++; $display("FAIL var_first_latency: got %0d expected 4", lat); end
            end else begin
                checks++; if (lat < 3 || lat > 6) begin errors++; $display("FAIL var_latency[%0d]: got %0d expected 3..6", r, lat); end
            end
            checks++; if (nb !== 4) begin errors++; $display("FAIL var_beats[%0d]: got %0d expected 4", r, nb); end
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_alias();
        test_simultaneous();
        test_reset_mid_burst();
        test_zero_latency();
`ifdef BMEM_VARIABLE_LATENCY_EN
        test_var_latency();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bmem_burst_responder.md
Name: bmem_burst_responder

Overview:
- Responder (memory) end of the 64-bit burst memory interface driven by the cacheline adaptor.
- Accepts one line request at a time and serves each 256-bit line as 4 consecutive 64-bit beats, for both reads and writes.
- Backed by an internal array of cache lines.
- Used as the synthesizable memory behind the top-level bmem_* ports in benches and FPGA builds.

Parameters:
- ADDR_BITS, 8, number of line-index bits; the array holds 2**ADDR_BITS lines of 256 bits.
- LATENCY, 4, idle cycles between request acceptance and the first beat; legal range 0..15.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- bmem_address  input  32  byte address of the line; bits [4:0] ignored
- bmem_read  input  1  read request; held high by the initiator until the final beat
- bmem_write  input  1  write request; held high by the initiator until the final beat
- bmem_wdata  input  64  write beat data; the initiator presents beat k until that beat's resp
- bmem_rdata  output  64  read beat data; valid only while bmem_resp is high during a read
- bmem_resp  output  1  beat strobe; exactly 4 consecutive high cycles per request
- busy  output  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: bmem_resp=0, bmem_rdata=0, busy=0, state=IDLE, beat counter=0, latency counter=0. Array contents are not reset.
- States: IDLE, WAIT, RBURST, WBURST, DONE.
- IDLE:
  - Samples bmem_read/bmem_write every cycle.
  - On a request, captures line index = bmem_address[5 +: ADDR_BITS]; upper address bits are ignored, so addresses alias/wrap. Captures direction.
  - Loads the latency counter with LATENCY.
  - Next state: WAIT if LATENCY>0; otherwise RBURST or WBURST by direction.
- Simultaneous read and write in IDLE: read wins; write is ignored for that request.
- WAIT: decrements the latency counter each cycle; at 1, moves to RBURST or WBURST. With the request accepted in cycle T, the first resp is in cycle T+1+LATENCY.
- RBURST:
  - bmem_resp=1 for beats 0..3 in consecutive cycles.
  - bmem_rdata = line[64*k +: 64]; beat 0 is the low word.
  - bmem_rdata is registered so data and resp align in the same cycle.
- WBURST:
  - bmem_resp=1 for beats 0..3 in consecutive cycles.
  - In the cycle resp is high for beat k, bmem_wdata is written to line[64*k +: 64]. Each beat commits individually.
- After beat 3, the next state is DONE.
- DONE: one cycle with resp=0; requests are ignored; then IDLE. This tolerates an initiator that drops its request one cycle after the final resp. The earliest next request is accepted 2 cycles after the final beat.
- Request inputs are not re-checked outside IDLE. Changing the address or direction mid-request has no effect on the current burst.
- Read-after-write to the same line returns the new data; there is no hazard window because requests are serialized.
- Reset mid-burst: the next cycle is IDLE with resp=0. Write beats already committed stay in the array; uncommitted beats are lost.
- bmem_rdata holds its last value when resp=0.

Optional Feature:
- Macro: BMEM_VARIABLE_LATENCY_EN.
- When defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded to 8'hA5 on reset, advances once per accepted request.
  - Per-request latency is LATENCY + lfsr[1:0] (0..3 extra cycles), taken from the LFSR value before it advances.
  - Beats within a burst remain consecutive.
- When undefined: latency is exactly LATENCY for every request; no LFSR logic.

Test Plan:
- Write then read, LATENCY=4: write line 0x0000_0040 with beats 0x1111.., 0x2222.., 0x3333.., 0x4444.. (64-bit repeats); accept at T -> resp high T+5..T+8. Read the same address -> rdata beats in order 0x1111..,0x2222..,0x3333..,0x4444.., resp on 4 consecutive cycles starting 5 cycles after acceptance.
- Aliasing, ADDR_BITS=8: write 0xDEAD.. beats to 0x0000_2000 (index 0); read 0x0000_0000 -> returns 0xDEAD.. beats. Bits [4:0]=0x1F on the read -> same data.
- Simultaneous read=write=1 at 0x80 -> read burst occurs, line 0x80 unchanged on later read. In DONE, read held high one extra cycle -> no second burst starts; busy=0 the cycle after DONE.
- LATENCY=0: read accepted at T -> resp high T+1..T+4. Back-to-back requests -> second request's first resp no earlier than T+7.
- Reset after write beat 1 of a burst to 0x100 -> resp=0 and busy=0 next cycle. Subsequent read of 0x100 -> beats 0..1 new, beats 2..3 old.
- With BMEM_VARIABLE_LATENCY_EN, LATENCY=2: after reset, first request latency = 2 + (8'hA5 & 3) = 3, so first resp at T+4. 64 random requests -> every latency in 2..5, every burst exactly 4 consecutive beats.
